// File: rtl/mcycle_pkg.sv
// mcycle_pkg: shared state encoding, op codes and defaults for the multi-cycle sequencer
package mcycle_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_WB, S_ABORT} state_e;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  localparam int TIMEOUT_CYCLES_DEF = 40;
endpackage

// File: rtl/mcycle_if.sv
// mcycle_if: sequencer-to-multi-cycle-unit bus (master = sequencer, slave = unit)
interface mcycle_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             busy;
  logic [WIDTH-1:0] result;
  modport master(output start, op, op1, op2, input busy, result);
  modport slave(input start, op, op1, op2, output busy, result);
endinterface

// File: rtl/mcycle_watchdog.sv
// mcycle_watchdog: saturating RUN-cycle counter flagging the cycle whose increment reaches the limit
module mcycle_watchdog #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign expired_o = en_i && ({1'b0, cnt_q} + {{W{1'b0}}, 1'b1} >= {1'b0, limit_i});
endmodule

// File: rtl/mcycle_sequencer.sv
// mcycle_sequencer: stalls the core while a MUL/DIV runs on the multi-cycle unit, then writes back
module mcycle_sequencer
  import mcycle_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_i,
  input  logic             req_op_i,
  input  logic [3:0]       req_rd_i,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  output logic             stall_o,
  output logic             wb_en_o,
  output logic [3:0]       wb_rd_o,
  output logic [WIDTH-1:0] wb_data_o,
  output logic             timeout_o,
  mcycle_if.master         m
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic [3:0]       rd_q, rd_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             to_q, to_d;
  logic             wd_clr, wd_en, wd_exp;
  logic             dbz;
  assign dbz = req_op_i == OP_DIV && req_b_i == '0;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    to_d    = to_q;
    stall_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_o = req_i;
        if (req_i) begin
          op_d    = req_op_i;
          rd_d    = req_rd_i;
          a_d     = req_a_i;
          b_d     = req_b_i;
          res_d   = dbz ? '1 : res_q;
          state_d = dbz ? S_WB : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        stall_o = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        stall_o = 1'b1;
        if (!m.busy) begin
          res_d   = m.result;
          state_d = S_WB;
        end else if (wd_exp) begin
          to_d    = 1'b1;
          state_d = S_ABORT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      to_q    <= to_d;
    end
  assign wd_clr = state_d == S_LAUNCH;
  assign wd_en  = state_q == S_RUN && m.busy;
  mcycle_watchdog #(.W(CW)) u_wd (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .limit_i  (CW'(TIMEOUT_CYCLES)),
    .expired_o(wd_exp)
  );
  assign m.start   = state_q == S_LAUNCH;
  assign m.op      = op_q;
  assign m.op1     = a_q;
  assign m.op2     = b_q;
  assign wb_en_o   = state_q == S_WB;
  assign wb_rd_o   = rd_q;
  assign wb_data_o = res_q;
  assign timeout_o = to_q;
endmodule

// File: tb/tb_mcycle_sequencer.sv
// tb_mcycle_sequencer: directed checks of the sequencer against a simple busy/result unit model
module tb_mcycle_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, req_op;
  logic [3:0]  req_rd;
  logic [31:0] req_a, req_b;
  logic        stall_o, wb_en_o, timeout_o;
  logic [3:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        hang;
  int          lat;
  logic [5:0]  ucnt = '0;
  logic [31:0] ures = '0;
  int n_vec = 0, n_err = 0;
  int cyc = 0, req_cyc = 0;
  int n_start, n_stall, n_wb;
  int scyc[4], wcyc[4];
  logic [3:0]  wrd[4];
  logic [31:0] wdat[4];
  mcycle_if #(.WIDTH(32)) mif ();
  mcycle_sequencer #(.WIDTH(32), .TIMEOUT_CYCLES(40)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_op_i(req_op), .req_rd_i(req_rd),
    .req_a_i(req_a), .req_b_i(req_b), .stall_o(stall_o), .wb_en_o(wb_en_o),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .timeout_o(timeout_o), .m(mif)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // unit model: busy rises with start, stays high for lat cycles in total, then drops with the result
  always @(posedge clk)
    if (mif.start) begin
      ucnt <= 6'(lat - 1);
      ures <= mif.op ? (mif.op2 != 0 ? mif.op1 / mif.op2 : '1) : mif.op1 * mif.op2;
    end else if (ucnt != 0) ucnt <= ucnt - 1'b1;
  assign mif.busy   = hang | mif.start | (ucnt != 0);
  assign mif.result = ures;
  always @(negedge clk) begin
    if (mif.start) begin
      if (n_start < 4) scyc[n_start] = cyc - req_cyc;
      n_start++;
    end
    if (stall_o) n_stall++;
    if (wb_en_o) begin
      if (n_wb < 4) begin
        wcyc[n_wb] = cyc - req_cyc;
        wrd[n_wb]  = wb_rd_o;
        wdat[n_wb] = wb_data_o;
      end
      n_wb++;
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr_mon();
    n_start = 0;
    n_stall = 0;
    n_wb    = 0;
  endtask
  task automatic do_req(input logic op, input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b, input int l);
    @(posedge clk);
    #1;
    lat = l; req_op = op; req_rd = rd; req_a = a; req_b = b; req = 1'b1;
    req_cyc = cyc;
    @(posedge clk);
    #1 req = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; req = 1'b0; req_op = 1'b0; req_rd = '0; req_a = '0; req_b = '0;
    hang = 1'b0; lat = 1;
    clr_mon();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_en", wb_en_o, 0);
    chk("rst_start", mif.start, 0);
    chk("rst_op", mif.op, 0);
    chk("rst_op1", mif.op1, 0);
    chk("rst_op2", mif.op2, 0);
    chk("rst_wb_rd", wb_rd_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_stall_lo", stall_o, 0);
    req = 1'b1;
    #1 chk("rst_stall_follows_req", stall_o, 1);
    req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    clr_mon();
    do_req(1'b0, 4'd3, 32'd7, 32'd6, 33);
    repeat (4) @(posedge clk);
    #1;
    chk("mul_op_held", mif.op, 0);
    chk("mul_op1_held", mif.op1, 7);
    chk("mul_op2_held", mif.op2, 6);
    repeat (46) @(posedge clk);
    chk("mul_starts", n_start, 1);
    chk("mul_stall_cycles", n_stall, 35);
    chk("mul_wb_count", n_wb, 1);
    chk("mul_wb_rd", wrd[0], 3);
    chk("mul_wb_data", wdat[0], 42);
    chk("mul_latency", wcyc[0], 35);
    clr_mon();
    do_req(1'b1, 4'd4, 32'd100, 32'd7, 10);
    repeat (30) @(posedge clk);
    chk("div_starts", n_start, 1);
    chk("div_stall_cycles", n_stall, 12);
    chk("div_wb_count", n_wb, 1);
    chk("div_wb_rd", wrd[0], 4);
    chk("div_wb_data", wdat[0], 14);
    clr_mon();
    do_req(1'b1, 4'd5, 32'd100, 32'd0, 10);
    repeat (10) @(posedge clk);
    chk("dbz_starts", n_start, 0);
    chk("dbz_stall_cycles", n_stall, 1);
    chk("dbz_wb_count", n_wb, 1);
    chk("dbz_wb_rd", wrd[0], 5);
    chk("dbz_wb_data", wdat[0], 32'hFFFF_FFFF);
    chk("dbz_latency", wcyc[0], 1);
    clr_mon();
    hang = 1'b1;
    repeat (5) @(posedge clk);
    #1 hang = 1'b0;
    repeat (3) @(posedge clk);
    chk("idle_busy_wb", n_wb, 0);
    chk("idle_busy_start", n_start, 0);
    chk("idle_busy_stall", n_stall, 0);
    clr_mon();
    @(posedge clk);
    #1;
    lat = 4; req_op = 1'b0; req_rd = 4'd1; req_a = 32'd3; req_b = 32'd5; req = 1'b1;
    req_cyc = cyc;
    @(posedge clk);
    #1;
    req_rd = 4'd2; req_a = 32'd4; req_b = 32'd4;
    repeat (7) @(posedge clk);
    #1 req = 1'b0;
    repeat (20) @(posedge clk);
    chk("b2b_wb_count", n_wb, 2);
    chk("b2b_starts", n_start, 2);
    chk("b2b_rd_first", wrd[0], 1);
    chk("b2b_rd_second", wrd[1], 2);
    chk("b2b_data_first", wdat[0], 15);
    chk("b2b_data_second", wdat[1], 16);
    chk("b2b_wb_first_cyc", wcyc[0], 6);
    chk("b2b_start2_cyc", scyc[1], 8);
    chk("b2b_wb_second_cyc", wcyc[1], 13);
    clr_mon();
    hang = 1'b1;
    do_req(1'b0, 4'd7, 32'd2, 32'd2, 5);
    repeat (60) @(posedge clk);
    chk("hang_wb_count", n_wb, 0);
    chk("hang_starts", n_start, 1);
    chk("hang_timeout", timeout_o, 1);
    chk("hang_stall_cycles", n_stall, 42);
    hang = 1'b0;
    repeat (3) @(posedge clk);
    clr_mon();
    do_req(1'b0, 4'd8, 32'd2, 32'd3, 3);
    repeat (15) @(posedge clk);
    chk("post_abort_data", wdat[0], 6);
    chk("timeout_sticky", timeout_o, 1);
    clr_mon();
    do_req(1'b0, 4'd9, 32'd7, 32'd6, 33);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_wb_en", wb_en_o, 0);
    chk("mrst_start", mif.start, 0);
    chk("mrst_op1", mif.op1, 0);
    chk("mrst_op2", mif.op2, 0);
    chk("mrst_wb_rd", wb_rd_o, 0);
    chk("mrst_wb_data", wb_data_o, 0);
    chk("mrst_timeout", timeout_o, 0);
    chk("mrst_stall", stall_o, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (50) @(posedge clk);
    chk("mrst_no_wb", n_wb, 0);
    chk("mrst_one_start", n_start, 1);
    clr_mon();
    do_req(1'b0, 4'd6, 32'd9, 32'd9, 5);
    repeat (20) @(posedge clk);
    chk("after_rst_wb_count", n_wb, 1);
    chk("after_rst_wb_rd", wrd[0], 6);
    chk("after_rst_wb_data", wdat[0], 81);
    chk("after_rst_latency", wcyc[0], 7);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
